// File: rtl/branch_ctrl_pkg.sv
// rtl/branch_ctrl_pkg.sv - shared encodings and helpers for the decode-stage branch sequencer
package branch_ctrl_pkg;

  localparam int ADDRWIDTH = 32;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_J    = 2'b11
  } br_type_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STALL   = 2'd1,
    S_RESOLVE = 2'd2
  } state_e;

  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  // Stall cycles one operand needs, and where its value comes from once those have elapsed.
  typedef struct packed {
    logic [1:0] n;
    logic [1:0] fwd;
  } hazard_t;

  function automatic logic is_taken(input br_type_e t, input logic eq);
    return (t == BR_BEQ && eq) || (t == BR_BNE && !eq) || (t == BR_J);
  endfunction

endpackage

// File: rtl/branch_ctrl_hazard_detect.sv
// rtl/branch_ctrl_hazard_detect.sv - combinational RAW check of branch compare operands
module branch_hazard_detect
  import branch_ctrl_pkg::*;
#(
  parameter int NB_REG = 5
) (
  input  logic [1:0]        branch_type_i,
  input  logic [NB_REG-1:0] rs_i,
  input  logic [NB_REG-1:0] rt_i,
  input  logic              ex_reg_write_i,
  input  logic              ex_mem_read_i,
  input  logic [NB_REG-1:0] ex_rd_i,
  input  logic              mem_reg_write_i,
  input  logic              mem_mem_read_i,
  input  logic [NB_REG-1:0] mem_rd_i,
  output logic [1:0]        n_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o
);

  // The EX producer is younger than the MEM one, so it owns the value when both match.
  function automatic hazard_t check_opnd(
    input logic [NB_REG-1:0] r,
    input logic ex_wr, input logic ex_ld, input logic [NB_REG-1:0] ex_rd,
    input logic mem_wr, input logic mem_ld, input logic [NB_REG-1:0] mem_rd
  );
    hazard_t h;
    h.n   = 2'd0;
    h.fwd = FWD_REG;
    if (r != '0) begin
      if (ex_wr && ex_rd == r) begin
        h.n   = ex_ld ? 2'd2 : 2'd1;
        h.fwd = ex_ld ? FWD_MEMWB : FWD_EXMEM;
      end else if (mem_wr && mem_rd == r) begin
        h.n   = mem_ld ? 2'd1 : 2'd0;
        h.fwd = mem_ld ? FWD_MEMWB : FWD_EXMEM;
      end
    end
    return h;
  endfunction

  hazard_t hz_a, hz_b;
  logic    compares;

  always_comb begin
    compares = (branch_type_i == BR_BEQ) || (branch_type_i == BR_BNE);
    hz_a = check_opnd(rs_i, ex_reg_write_i, ex_mem_read_i, ex_rd_i,
                      mem_reg_write_i, mem_mem_read_i, mem_rd_i);
    hz_b = check_opnd(rt_i, ex_reg_write_i, ex_mem_read_i, ex_rd_i,
                      mem_reg_write_i, mem_mem_read_i, mem_rd_i);
    if (!compares) begin
      hz_a = '0;
      hz_b = '0;
    end
    n_o     = (hz_a.n > hz_b.n) ? hz_a.n : hz_b.n;
    fwd_a_o = hz_a.fwd;
    fwd_b_o = hz_b.fwd;
  end

endmodule

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - decode-stage branch sequencer: hazard stall, compare forwarding, redirect
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int NB_REG = 5,
  parameter int NB_CNT = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [1:0]           i_branch_type,
  input  logic [NB_REG-1:0]    i_rs,
  input  logic [NB_REG-1:0]    i_rt,
  input  logic                 i_is_equal,
  input  logic [ADDRWIDTH-1:0] i_branch_address,
  input  logic                 i_ex_reg_write,
  input  logic                 i_ex_mem_read,
  input  logic [NB_REG-1:0]    i_ex_rd,
  input  logic                 i_mem_reg_write,
  input  logic                 i_mem_mem_read,
  input  logic [NB_REG-1:0]    i_mem_rd,
  output logic                 o_stall,
  output logic [1:0]           o_fwd_a,
  output logic [1:0]           o_fwd_b,
  output logic                 o_pc_src,
  output logic [ADDRWIDTH-1:0] o_pc_target,
  output logic                 o_flush,
  output logic [NB_CNT-1:0]    o_taken_cnt
);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  br_type_e          type_q, type_d;
  logic [NB_CNT-1:0] taken_cnt_q, taken_cnt_d;

  logic [1:0] hz_n, hz_fwd_a, hz_fwd_b;
  logic [1:0] fwd_a, fwd_b;
  logic       stall, resolve, taken, active;
  br_type_e   res_type;

  branch_hazard_detect #(.NB_REG(NB_REG)) u_hazard (
    .branch_type_i   (i_branch_type),
    .rs_i            (i_rs),
    .rt_i            (i_rt),
    .ex_reg_write_i  (i_ex_reg_write),
    .ex_mem_read_i   (i_ex_mem_read),
    .ex_rd_i         (i_ex_rd),
    .mem_reg_write_i (i_mem_reg_write),
    .mem_mem_read_i  (i_mem_mem_read),
    .mem_rd_i        (i_mem_rd),
    .n_o             (hz_n),
    .fwd_a_o         (hz_fwd_a),
    .fwd_b_o         (hz_fwd_b)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fwd_a_d  = fwd_a_q;
    fwd_b_d  = fwd_b_q;
    type_d   = type_q;
    stall    = 1'b0;
    resolve  = 1'b0;
    res_type = br_type_e'(i_branch_type);
    fwd_a    = fwd_a_q;
    fwd_b    = fwd_b_q;
    case (state_q)
      S_IDLE: begin
        fwd_a = hz_fwd_a;
        fwd_b = hz_fwd_b;
        if (br_type_e'(i_branch_type) != BR_NONE) begin
          if (hz_n == 2'd0) begin
            resolve = 1'b1;
          end else begin
            stall   = 1'b1;
            cnt_d   = hz_n - 2'd1;
            fwd_a_d = hz_fwd_a;
            fwd_b_d = hz_fwd_b;
            type_d  = br_type_e'(i_branch_type);
            state_d = (hz_n == 2'd1) ? S_RESOLVE : S_STALL;
          end
        end
      end
      S_STALL: begin
        stall = 1'b1;
        cnt_d = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) state_d = S_RESOLVE;
      end
      S_RESOLVE: begin
        // The branch sitting in ID is not re-examined; the selects latched on entry apply.
        resolve  = 1'b1;
        res_type = type_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    taken       = resolve && is_taken(res_type, i_is_equal);
    taken_cnt_d = taken_cnt_q + NB_CNT'(taken);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      fwd_a_q     <= FWD_REG;
      fwd_b_q     <= FWD_REG;
      type_q      <= BR_NONE;
      taken_cnt_q <= '0;
    end else if (i_enable) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      type_q      <= type_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign active      = i_enable && !i_reset;
  assign o_stall     = stall && active;
  assign o_pc_src    = taken && active;
  assign o_flush     = taken && active;
  assign o_fwd_a     = i_reset ? FWD_REG : fwd_a;
  assign o_fwd_b     = i_reset ? FWD_REG : fwd_b;
  assign o_pc_target = i_branch_address;
  assign o_taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - directed and randomized bench for branch_ctrl against a transaction model
module tb_branch_ctrl;
  import branch_ctrl_pkg::*;

  localparam int NB_REG = 5;
  localparam int NB_CNT = 4;
  localparam int AW     = ADDRWIDTH;

  logic              clk = 1'b0;
  logic              rst, en, eq;
  logic [1:0]        br;
  logic [NB_REG-1:0] rs, rt, ex_rd, mem_rd;
  logic              ex_wr, ex_ld, mem_wr, mem_ld;
  logic [AW-1:0]     addr;
  logic              stall, pc_src, flush;
  logic [1:0]        fwd_a, fwd_b;
  logic [AW-1:0]     target;
  logic [NB_CNT-1:0] tcnt;

  int n_vec = 0;
  int n_err = 0;
  bit model_on = 1'b0;

  bit m_busy   = 1'b0;
  int m_remain = 0;
  int m_fa = 0, m_fb = 0, m_type = 0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.NB_REG(NB_REG), .NB_CNT(NB_CNT)) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_branch_type(br),
    .i_rs(rs), .i_rt(rt), .i_is_equal(eq), .i_branch_address(addr),
    .i_ex_reg_write(ex_wr), .i_ex_mem_read(ex_ld), .i_ex_rd(ex_rd),
    .i_mem_reg_write(mem_wr), .i_mem_mem_read(mem_ld), .i_mem_rd(mem_rd),
    .o_stall(stall), .o_fwd_a(fwd_a), .o_fwd_b(fwd_b), .o_pc_src(pc_src),
    .o_pc_target(target), .o_flush(flush), .o_taken_cnt(tcnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Nearest in-flight writer of x: cycles to wait, then the source to compare from.
  task automatic opnd(input int x, output int n, output int f);
    n = 0;
    f = 0;
    if (x != 0) begin
      if (ex_wr && int'(ex_rd) == x) begin
        n = ex_ld ? 2 : 1;
        f = ex_ld ? 2 : 1;
      end else if (mem_wr && int'(mem_rd) == x) begin
        n = mem_ld ? 1 : 0;
        f = mem_ld ? 2 : 1;
      end
    end
  endtask

  always @(negedge clk) begin
    int na, nb, fa, fb, n, rtype, efa, efb;
    bit res, tk, exp_stall, act;
    if (model_on) begin
      na = 0; nb = 0; fa = 0; fb = 0; n = 0; efa = 0; efb = 0;
      rtype = 0; res = 1'b0; exp_stall = 1'b0;
      if (!m_busy) begin
        if (br == 2'd1 || br == 2'd2) begin
          opnd(int'(rs), na, fa);
          opnd(int'(rt), nb, fb);
        end
        n = (na > nb) ? na : nb;
        if (br != 2'd0) begin
          if (n == 0) begin
            res = 1'b1; rtype = int'(br); efa = fa; efb = fb;
          end else begin
            exp_stall = 1'b1;
          end
        end
      end else if (m_remain > 0) begin
        exp_stall = 1'b1;
      end else begin
        res = 1'b1; rtype = m_type; efa = m_fa; efb = m_fb;
      end
      tk  = res && (rtype == 3 || (rtype == 1 && eq) || (rtype == 2 && !eq));
      act = !rst && en;
      chk("stall", 64'(stall), 64'(exp_stall && act));
      chk("pc_src", 64'(pc_src), 64'(tk && act));
      chk("flush", 64'(flush), 64'(tk && act));
      chk("pc_target", 64'(target), 64'(addr));
      chk("taken_cnt", 64'(tcnt), 64'(m_cnt));
      if (res && act) begin
        chk("fwd_a", 64'(fwd_a), 64'(efa));
        chk("fwd_b", 64'(fwd_b), 64'(efb));
      end
      if (rst) begin
        m_busy = 1'b0;
        m_cnt  = 0;
      end else if (en) begin
        if (tk) m_cnt = (m_cnt + 1) % (1 << NB_CNT);
        if (!m_busy) begin
          if (br != 2'd0 && n > 0) begin
            m_busy = 1'b1; m_remain = n - 1; m_fa = fa; m_fb = fb; m_type = int'(br);
          end
        end else if (m_remain > 0) begin
          m_remain--;
        end else begin
          m_busy = 1'b0;
        end
      end
    end
  end

  task automatic idle_in();
    br = 2'd0; rs = '0; rt = '0; eq = 1'b0;
    ex_wr = 1'b0; ex_ld = 1'b0; ex_rd = '0;
    mem_wr = 1'b0; mem_ld = 1'b0; mem_rd = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; addr = '0;
    idle_in();
    next();
    next();
    model_on = 1'b1;
    @(negedge clk);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_cnt", 64'(tcnt), 64'd0);

    // BEQ r1,r2, no producers, equal: redirect in the same cycle
    next(); rst = 1'b0;
    br = 2'd1; rs = 5'd1; rt = 5'd2; eq = 1'b1; addr = 32'h40;
    @(negedge clk);
    chk("t1_pc_src", 64'(pc_src), 64'd1);
    chk("t1_flush", 64'(flush), 64'd1);
    chk("t1_stall", 64'(stall), 64'd0);
    chk("t1_target", 64'(target), 64'h40);
    next(); idle_in();
    @(negedge clk);
    chk("t1_cnt", 64'(tcnt), 64'd1);

    // BNE r3,r4 with EX ALU writing r3: one bubble then forward from EX/MEM
    next(); br = 2'd2; rs = 5'd3; rt = 5'd4; eq = 1'b1; ex_wr = 1'b1; ex_rd = 5'd3;
    @(negedge clk);
    chk("t2_stall", 64'(stall), 64'd1);
    next(); ex_wr = 1'b0; mem_wr = 1'b1; mem_rd = 5'd3;
    @(negedge clk);
    chk("t2_res_stall", 64'(stall), 64'd0);
    chk("t2_fwd_a", 64'(fwd_a), 64'd1);
    chk("t2_pc_src", 64'(pc_src), 64'd0);

    // BEQ r5,r5 with EX load to r5: two bubbles then forward from MEM/WB
    next(); idle_in(); br = 2'd1; rs = 5'd5; rt = 5'd5; eq = 1'b1;
    ex_wr = 1'b1; ex_ld = 1'b1; ex_rd = 5'd5;
    @(negedge clk);
    chk("t3_stall1", 64'(stall), 64'd1);
    next(); ex_wr = 1'b0; ex_ld = 1'b0; mem_wr = 1'b1; mem_ld = 1'b1; mem_rd = 5'd5;
    @(negedge clk);
    chk("t3_stall2", 64'(stall), 64'd1);
    next(); mem_wr = 1'b0; mem_ld = 1'b0;
    @(negedge clk);
    chk("t3_stall3", 64'(stall), 64'd0);
    chk("t3_fwd_a", 64'(fwd_a), 64'd2);
    chk("t3_fwd_b", 64'(fwd_b), 64'd2);
    chk("t3_pc_src", 64'(pc_src), 64'd1);

    // r0 never hazards; MEM ALU producer forwards without stalling
    next(); idle_in(); br = 2'd1; eq = 1'b1; ex_wr = 1'b1; ex_ld = 1'b1;
    @(negedge clk);
    chk("t4_r0_stall", 64'(stall), 64'd0);
    chk("t4_r0_fwd_a", 64'(fwd_a), 64'd0);
    chk("t4_r0_pc_src", 64'(pc_src), 64'd1);
    next(); idle_in(); br = 2'd1; rs = 5'd6; rt = 5'd7; mem_wr = 1'b1; mem_rd = 5'd6;
    @(negedge clk);
    chk("t4_mem_stall", 64'(stall), 64'd0);
    chk("t4_mem_fwd_a", 64'(fwd_a), 64'd1);
    chk("t4_mem_fwd_b", 64'(fwd_b), 64'd0);
    chk("t4_cnt", 64'(tcnt), 64'd3);

    // enable dropped for three cycles in the middle of a load stall
    next(); idle_in(); br = 2'd1; rs = 5'd5; rt = 5'd5; ex_wr = 1'b1; ex_ld = 1'b1; ex_rd = 5'd5;
    @(negedge clk);
    chk("t5_stall", 64'(stall), 64'd1);
    for (int i = 0; i < 3; i++) begin
      next(); en = 1'b0;
      @(negedge clk);
      chk("t5_hold_stall", 64'(stall), 64'd0);
    end
    next(); en = 1'b1;
    @(negedge clk);
    chk("t5_resume_stall", 64'(stall), 64'd1);
    next();
    @(negedge clk);
    chk("t5_res_stall", 64'(stall), 64'd0);
    chk("t5_res_fwd_a", 64'(fwd_a), 64'd2);
    chk("t5_cnt", 64'(tcnt), 64'd3);

    // reset mid-stall, then an immediate jump
    next(); idle_in(); br = 2'd2; rs = 5'd3; rt = 5'd4; ex_wr = 1'b1; ex_ld = 1'b1; ex_rd = 5'd3;
    @(negedge clk);
    chk("t6_stall", 64'(stall), 64'd1);
    next(); rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_stall", 64'(stall), 64'd0);
    chk("t6_rst_pc_src", 64'(pc_src), 64'd0);
    next(); rst = 1'b0; idle_in();
    @(negedge clk);
    chk("t6_idle_stall", 64'(stall), 64'd0);
    chk("t6_idle_cnt", 64'(tcnt), 64'd0);
    next(); br = 2'd3; addr = 32'h1234;
    @(negedge clk);
    chk("t6_j_pc_src", 64'(pc_src), 64'd1);
    chk("t6_j_stall", 64'(stall), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      next();
      rst    = ($urandom_range(0, 199) == 0);
      en     = ($urandom_range(0, 9) != 0);
      br     = 2'($urandom_range(0, 3));
      rs     = NB_REG'($urandom_range(0, 7));
      rt     = NB_REG'($urandom_range(0, 7));
      eq     = 1'($urandom_range(0, 1));
      addr   = AW'($urandom);
      ex_ld  = ($urandom_range(0, 2) == 0);
      ex_wr  = ex_ld || ($urandom_range(0, 1) == 1);
      ex_rd  = NB_REG'($urandom_range(0, 7));
      mem_ld = ($urandom_range(0, 2) == 0);
      mem_wr = mem_ld || ($urandom_range(0, 1) == 1);
      mem_rd = NB_REG'($urandom_range(0, 7));
    end
    next();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
